// File: rtl/console_rxfifo_pkg.sv
// Shared constants and types for the console receive FIFO: the simpleuart
// "no data" marker, the drain FSM encoding and the default buffer depth.
package console_rxfifo_pkg;

  localparam logic [31:0] UART_NODATA   = 32'hFFFF_FFFF;
  localparam int          DEFAULT_DEPTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } drain_state_e;

  // A simpleuart data word carries a byte whenever it differs from the marker.
  function automatic logic uart_has_byte(input logic [31:0] dat);
    return dat != UART_NODATA;
  endfunction

endpackage

// File: rtl/console_rxfifo_mem.sv
// DEPTH x 8 register array: synchronous write, asynchronous read so the head
// byte is visible to the CPU in the same cycle it samples rd_data.
module console_rxfifo_mem #(
  parameter int DEPTH = console_rxfifo_pkg::DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  // NOTE: the array has no reset; occupancy is tracked by the pointers, so
  // stale entries are never presented and resetting them would only cost logic.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/console_rxfifo.sv
// Console receive buffer: drains simpleuart bytes into a small FIFO as soon
// as they are valid and offers the CPU a non-blocking head-of-queue read port.
module console_rxfifo
  import console_rxfifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] uart_dat_do,
  output logic        uart_dat_re,
  input  logic        rd_re,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic [AW:0] count,
  output logic        overflow,
  input  logic        overflow_clr
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  drain_state_e  state_q, state_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          ack_q, ack_d;

  logic          offer;
  logic          push;
  logic          drop;
  logic          pop;
  logic [7:0]    head_byte;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    ack_d      = 1'b0;

    // The fullness test uses the pre-pop count, so a push at DEPTH is dropped
    // even when the CPU pops in the same cycle.
    offer = (state_q == IDLE) && uart_has_byte(uart_dat_do);
    push  = offer && (count_q != FULL_COUNT);
    drop  = offer && (count_q == FULL_COUNT);
    pop   = rd_re && (count_q != '0);

    unique case (state_q)
      IDLE: begin
        if (offer) begin
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (push) begin
      wp_d = wp_q + 1'b1;
    end
    if (pop) begin
      rp_d = rp_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      ack_q      <= ack_d;
    end
  end

  console_rxfifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wp_q),
    .wdata (uart_dat_do[7:0]),
    .raddr (rp_q),
    .rdata (head_byte)
  );

  assign uart_dat_re = ack_q;
  assign rd_valid    = (count_q != '0);
  assign rd_data     = rd_valid ? {24'h0, head_byte} : 32'h0;
  assign count       = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_console_rxfifo.sv
// Self-checking bench for console_rxfifo: directed scenarios plus a random
// phase, all compared every cycle against a queue-based reference model.
module tb_console_rxfifo;

  localparam int          DEPTH  = 16;
  localparam int          AW     = $clog2(DEPTH);
  localparam logic [31:0] NODATA = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] uart_dat_do;
  logic        uart_dat_re;
  logic        rd_re;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [AW:0] count;
  logic        overflow;
  logic        overflow_clr;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the buffer is a plain byte queue.
  logic [7:0] m_q[$];
  bit         m_ovf;
  bit         m_ack;

  console_rxfifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .uart_dat_do  (uart_dat_do),
    .uart_dat_re  (uart_dat_re),
    .rd_re        (rd_re),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .count        (count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".rd_valid"}, {31'b0, rd_valid}, {31'b0, m_q.size() != 0});
    check({tag, ".rd_data"}, rd_data, (m_q.size() != 0) ? {24'h0, m_q[0]} : 32'h0);
    check({tag, ".count"}, {{(31 - AW){1'b0}}, count}, m_q.size());
    check({tag, ".overflow"}, {31'b0, overflow}, {31'b0, m_ovf});
    check({tag, ".uart_dat_re"}, {31'b0, uart_dat_re}, {31'b0, m_ack});
  endtask

  // One clock: the model applies the rules to the pre-edge inputs and state,
  // then all outputs are compared 1 time unit after the edge.
  task automatic tick(input string tag);
    bit accept, do_pop, do_push, do_drop;
    accept  = !m_ack && (uart_dat_do != NODATA);
    do_pop  = rd_re && (m_q.size() != 0);
    do_push = accept && (m_q.size() < DEPTH);
    do_drop = accept && (m_q.size() == DEPTH);
    @(posedge clk);
    #1;
    if (!resetn) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_ack = 1'b0;
    end else begin
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back(uart_dat_do[7:0]);
      if (do_drop) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
      m_ack = accept;
    end
    check_model(tag);
  endtask

  // simpleuart behaviour: the byte stays valid through the ACK cycle and is
  // withdrawn at the edge that ends it.
  task automatic offer(input logic [7:0] b, input string tag);
    uart_dat_do = {24'h0, b};
    tick(tag);
    tick(tag);
    uart_dat_do = NODATA;
  endtask

  task automatic pop_one(input logic [7:0] exp, input string tag);
    check({tag, ".head"}, rd_data, {24'h0, exp});
    rd_re = 1'b1;
    tick(tag);
    rd_re = 1'b0;
  endtask

  initial begin
    resetn       = 1'b0;
    uart_dat_do  = NODATA;
    rd_re        = 1'b0;
    overflow_clr = 1'b0;
    m_ovf        = 1'b0;
    m_ack        = 1'b0;
    tick("reset");
    tick("reset");
    resetn = 1'b1;

    // 1: idle with no UART data
    for (int i = 0; i < 5; i++) tick("idle");
    check("idle.count", {27'b0, count}, 32'd0);

    // 2: single byte, exactly one ack pulse, then pop
    uart_dat_do = 32'h41;
    tick("t2");
    check("t2.ack_pulse", {31'b0, uart_dat_re}, 32'd1);
    check("t2.data", rd_data, 32'h0000_0041);
    tick("t2");
    uart_dat_do = NODATA;
    check("t2.ack_low", {31'b0, uart_dat_re}, 32'd0);
    check("t2.count", {27'b0, count}, 32'd1);
    pop_one(8'h41, "t2.pop");
    check("t2.empty_data", rd_data, 32'h0);

    // 3: four bytes in order
    for (int i = 0; i < 4; i++) offer(8'(8'h30 + i), "t3.push");
    check("t3.count4", {27'b0, count}, 32'd4);
    for (int i = 0; i < 4; i++) pop_one(8'(8'h30 + i), "t3.pop");
    check("t3.count0", {27'b0, count}, 32'd0);
    rd_re = 1'b1;
    tick("t3.pop_empty");
    rd_re = 1'b0;

    // 4: fill, drop on full, drain, clear overflow
    for (int i = 0; i < DEPTH; i++) offer(8'(i), "t4.fill");
    offer(8'h99, "t4.drop");
    check("t4.overflow", {31'b0, overflow}, 32'd1);
    check("t4.count_full", {27'b0, count}, 32'd16);
    // Full push with a simultaneous pop: push still dropped.
    uart_dat_do = 32'hAA;
    rd_re = 1'b1;
    tick("t4.full_pushpop");
    rd_re = 1'b0;
    tick("t4.full_pushpop");
    uart_dat_do = NODATA;
    check("t4.count15", {27'b0, count}, 32'd15);
    for (int i = 1; i < DEPTH; i++) pop_one(8'(i), "t4.drain");
    overflow_clr = 1'b1;
    tick("t4.clr");
    overflow_clr = 1'b0;
    check("t4.ovf_clr", {31'b0, overflow}, 32'd0);

    // 5: pointer wrap with occupancy held at 1..3
    for (int i = 0; i < 40; i++) begin
      uart_dat_do = {24'h0, 8'(i)};
      rd_re = (m_q.size() >= 2);
      tick("t5.wrap");
      rd_re = 1'b0;
      tick("t5.wrap");
      uart_dat_do = NODATA;
    end
    while (m_q.size() != 0) pop_one(m_q[0], "t5.tail");
    check("t5.no_ovf", {31'b0, overflow}, 32'd0);

    // 6: push and pop together at count 1, then reset during ACK
    offer(8'h55, "t6.seed");
    uart_dat_do = 32'h66;
    rd_re = 1'b1;
    tick("t6.pushpop");
    rd_re = 1'b0;
    tick("t6.pushpop");
    uart_dat_do = NODATA;
    check("t6.count1", {27'b0, count}, 32'd1);
    check("t6.data66", rd_data, 32'h0000_0066);
    for (int i = 0; i < 3; i++) offer(8'(8'h70 + i), "t6.fill");
    uart_dat_do = 32'h74;
    tick("t6.accept");
    check("t6.count5", {27'b0, count}, 32'd5);
    resetn = 1'b0;
    tick("t6.reset");
    uart_dat_do = NODATA;
    check("t6.rst_count", {27'b0, count}, 32'd0);
    check("t6.rst_valid", {31'b0, rd_valid}, 32'd0);
    check("t6.rst_ack", {31'b0, uart_dat_re}, 32'd0);
    resetn = 1'b1;
    tick("t6.post");

    // Random phase: protocol-correct UART offers, random pops and clears.
    for (int i = 0; i < 400; i++) begin
      overflow_clr = ($urandom_range(0, 15) == 0);
      rd_re        = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) begin
        uart_dat_do = {24'h0, 8'($urandom)};
        tick("rnd");
        rd_re        = ($urandom_range(0, 2) == 0);
        overflow_clr = 1'b0;
        tick("rnd");
        uart_dat_do = NODATA;
      end else begin
        tick("rnd");
      end
    end
    rd_re = 1'b0;
    overflow_clr = 1'b0;
    tick("end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
